// File: rtl/lfsr_draw.sv
// XNOR-feedback LFSR with runtime seeding, lockup recovery and a
// req/valid draw engine returning a value uniformly below a limit.
module lfsr_draw #(
    parameter int              WIDTH   = 16,
    parameter logic [WIDTH-1:0] TAPS    = 16'h100B,
    parameter logic [WIDTH-1:0] SEED    = '0,
    parameter int              OUT_W   = 4,
    parameter int              STEPS   = 4,
    parameter int              MAX_TRY = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic [OUT_W-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy,
    output logic             lockup_err,
    output logic [WIDTH-1:0] ps
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    localparam logic [7:0] STEP_INIT = 8'(STEPS);
    localparam logic [7:0] TRY_LAST  = 8'(MAX_TRY - 1);

    state_t           state, state_d;
    logic [7:0]       step_cnt, step_d;
    logic [7:0]       try_cnt, try_d;
    logic [OUT_W-1:0] lim_q, lim_d;
    logic [OUT_W-1:0] rnd_d;
    logic             rnd_valid_d;
    logic             lockup_d;
    logic [WIDTH-1:0] ps_d;
    logic             do_shift;
    logic             fb;
    logic [OUT_W-1:0] cand;

    assign fb   = ~^(ps & TAPS);
    assign cand = ps[OUT_W-1:0];
    assign busy = (state != IDLE);

    always_comb begin
        state_d     = state;
        step_d      = step_cnt;
        try_d       = try_cnt;
        lim_d       = lim_q;
        rnd_d       = rnd;
        rnd_valid_d = 1'b0;
        lockup_d    = 1'b0;
        ps_d        = ps;
        do_shift    = 1'b0;

        unique case (state)
            IDLE: begin
                do_shift = enable;
                if (req) begin
                    state_d = SHIFT;
                    lim_d   = limit;
                    step_d  = STEP_INIT;
                    try_d   = '0;
                end
            end
            SHIFT: begin
                do_shift = 1'b1;
                step_d   = step_cnt - 8'd1;
                if (step_cnt == 8'd1)
                    state_d = CHECK;
            end
            CHECK: begin
                if (lim_q == '0) begin
                    rnd_d       = '0;
                    rnd_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cand < lim_q) begin
                    rnd_d       = cand;
                    rnd_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (try_cnt < TRY_LAST) begin
                    try_d   = try_cnt + 8'd1;
                    step_d  = STEP_INIT;
                    state_d = SHIFT;
                end else begin
                    // Rejection budget spent: clamp to the top legal value.
                    rnd_d       = lim_q - OUT_W'(1);
                    rnd_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_shift) begin
            if (&ps) begin
                ps_d     = SEED;
                lockup_d = 1'b1;
            end else begin
                ps_d = {fb, ps[WIDTH-1:1]};
            end
        end

        // A seed load wins over everything and aborts any draw in flight.
        if (seed_load) begin
            ps_d        = seed;
            lockup_d    = 1'b0;
            state_d     = IDLE;
            rnd_d       = rnd;
            rnd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            step_cnt   <= '0;
            try_cnt    <= '0;
            lim_q      <= '0;
            rnd        <= '0;
            rnd_valid  <= 1'b0;
            lockup_err <= 1'b0;
            ps         <= SEED;
        end else begin
            state      <= state_d;
            step_cnt   <= step_d;
            try_cnt    <= try_d;
            lim_q      <= lim_d;
            rnd        <= rnd_d;
            rnd_valid  <= rnd_valid_d;
            lockup_err <= lockup_d;
            ps         <= ps_d;
        end
    end

endmodule

// File: tb/tb_lfsr_draw.sv
// Scoreboard bench for lfsr_draw: reference LFSR model predicts each
// draw's value, latency and final state.
module tb_lfsr_draw;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        seed_load;
    logic [15:0] seed;
    logic        req;
    logic [3:0]  limit;
    logic [3:0]  rnd;
    logic        rnd_valid;
    logic        busy;
    logic        lockup_err;
    logic [15:0] ps;

    typedef struct {
        logic [3:0]  rnd;
        int          lat;
        logic [15:0] ps;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] last_rnd;

    lfsr_draw dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .limit     (limit),
        .rnd       (rnd),
        .rnd_valid (rnd_valid),
        .busy      (busy),
        .lockup_err(lockup_err),
        .ps        (ps)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] p);
        if (p == 16'hFFFF) return 16'h0000;
        return {~^(p & 16'h100B), p[15:1]};
    endfunction

    function automatic exp_t model_draw(input logic [15:0] s,
                                        input logic [3:0] lim);
        exp_t e;
        logic [15:0] p;
        p     = s;
        e.lat = 0;
        e.rnd = 4'd0;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) p = lfsr_next(p);
            e.lat += 5;
            if (lim == 4'd0) begin
                e.rnd = 4'd0;
                break;
            end
            if (p[3:0] < lim) begin
                e.rnd = p[3:0];
                break;
            end
            if (k == 7) e.rnd = lim - 4'd1;
        end
        e.ps = p;
        return e;
    endfunction

    task automatic do_reset();
        reset     = 1'b0;
        enable    = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0;
        req       = 1'b0;
        limit     = 4'd0;
        #23;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        last_rnd = 4'd0;
    endtask

    // Seeds the LFSR (enable off), requests a draw and scores it.
    task automatic run_draw(input logic [15:0] s, input logic [3:0] lim,
                            input bit check_bounds);
        exp_t e;
        int   lat;
        bit   seen;
        enable    = 1'b0;
        seed_load = 1'b1;
        seed      = s;
        tick();
        seed_load = 1'b0;
        req       = 1'b1;
        limit     = lim;
        exp_q.push_back(model_draw(s, lim));
        tick();
        req  = 1'b0;
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (rnd_valid) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL draw_timeout: no rnd_valid in 60 edges, lim=%0d",
                     lim);
        end else begin
            n_vec += 3;
            if (rnd !== e.rnd) begin
                n_err++;
                $display("FAIL draw_rnd: got %0d want %0d (seed %h lim %0d)",
                         rnd, e.rnd, s, lim);
            end
            if (lat != e.lat) begin
                n_err++;
                $display("FAIL draw_lat: got %0d want %0d", lat, e.lat);
            end
            if (ps !== e.ps || busy !== 1'b0) begin
                n_err++;
                $display("FAIL draw_end: ps=%h busy=%b want ps=%h busy=0",
                         ps, busy, e.ps);
            end
            if (check_bounds) begin
                n_vec++;
                if ((lim != 0 && rnd >= lim) || lat % 5 != 0 || lat > 40) begin
                    n_err++;
                    $display("FAIL draw_bounds: rnd=%0d lim=%0d lat=%0d",
                             rnd, lim, lat);
                end
            end
            last_rnd = e.rnd;
        end
    endtask

    task automatic test_reset();
        logic [15:0] seq [5];
        seq = '{16'h8000, 16'hC000, 16'hE000, 16'hF000, 16'h7800};
        reset = 1'b0;
        enable = 1'b1;
        seed_load = 1'b0;
        seed = 16'h0;
        req = 1'b0;
        limit = 4'd0;
        #17;
        n_vec++;
        if (ps !== 16'h0 || rnd !== 4'd0 || rnd_valid !== 1'b0 ||
            busy !== 1'b0 || lockup_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_vals: ps=%h rnd=%0d v=%b busy=%b lk=%b",
                     ps, rnd, rnd_valid, busy, lockup_err);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (ps !== seq[i]) begin
                n_err++;
                $display("FAIL free_run_%0d: ps=%h want %h", i, ps, seq[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_basic_draw();
        exp_t e;
        int   lat;
        do_reset();
        req   = 1'b1;
        limit = 4'd15;
        exp_q.push_back(model_draw(16'h0000, 4'd15));
        tick();
        req = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL basic_busy: busy=%b at edge %0d want 1",
                         busy, n - 1);
            end
            tick();
            if (rnd_valid) begin
                lat = n;
                break;
            end
        end
        e = exp_q.pop_front();
        n_vec++;
        if (lat != 5 || lat != e.lat || rnd !== 4'd0 || ps !== 16'hF000 ||
            busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_draw: lat=%0d rnd=%0d ps=%h busy=%b want 5 0 f000 0",
                     lat, rnd, ps, busy);
        end
        tick();
        tick();
        n_vec++;
        if (rnd !== 4'd0 || rnd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_hold: rnd=%0d valid=%b want 0 0",
                     rnd, rnd_valid);
        end
    endtask

    task automatic test_zero_limit();
        int extra;
        run_draw(16'hACE1, 4'd3, 1'b0);
        run_draw(16'hACE1, 4'd0, 1'b0);
        n_vec++;
        if (rnd !== 4'd0) begin
            n_err++;
            $display("FAIL zero_limit: rnd=%0d want 0", rnd);
        end
        // req while busy must be ignored
        seed_load = 1'b1;
        seed      = 16'h5A5A;
        tick();
        seed_load = 1'b0;
        req       = 1'b1;
        limit     = 4'd0;
        tick();
        req = 1'b0;
        tick();
        req   = 1'b1;
        limit = 4'd15;
        tick();
        req   = 1'b0;
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (rnd_valid) extra++;
        end
        n_vec++;
        if (extra != 1 || busy !== 1'b0 || rnd !== 4'd0) begin
            n_err++;
            $display("FAIL ignored_req: pulses=%0d busy=%b rnd=%0d want 1 0 0",
                     extra, busy, rnd);
        end
        last_rnd = 4'd0;
    endtask

    task automatic test_lockup();
        enable    = 1'b0;
        seed_load = 1'b1;
        seed      = 16'hFFFF;
        tick();
        seed_load = 1'b0;
        enable    = 1'b1;
        n_vec++;
        if (ps !== 16'hFFFF || lockup_err !== 1'b0) begin
            n_err++;
            $display("FAIL lockup_load: ps=%h lk=%b want ffff 0", ps, lockup_err);
        end
        tick();
        n_vec++;
        if (ps !== 16'h0000 || lockup_err !== 1'b1) begin
            n_err++;
            $display("FAIL lockup_recover: ps=%h lk=%b want 0000 1",
                     ps, lockup_err);
        end
        tick();
        enable = 1'b0;
        n_vec++;
        if (ps !== 16'h8000 || lockup_err !== 1'b0) begin
            n_err++;
            $display("FAIL lockup_after: ps=%h lk=%b want 8000 0",
                     ps, lockup_err);
        end
    endtask

    task automatic test_abort();
        int pulses;
        run_draw(16'h0000, 4'd15, 1'b0);
        req   = 1'b1;
        limit = 4'd3;
        tick();
        req = 1'b0;
        tick();
        seed_load = 1'b1;
        seed      = 16'h1234;
        tick();
        seed_load = 1'b0;
        n_vec++;
        if (ps !== 16'h1234 || busy !== 1'b0 || rnd_valid !== 1'b0 ||
            rnd !== last_rnd) begin
            n_err++;
            $display("FAIL abort: ps=%h busy=%b v=%b rnd=%0d want 1234 0 0 %0d",
                     ps, busy, rnd_valid, rnd, last_rnd);
        end
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (rnd_valid) pulses++;
        end
        n_vec++;
        if (pulses != 0 || ps !== 16'h1234 || rnd !== last_rnd) begin
            n_err++;
            $display("FAIL abort_after: pulses=%0d ps=%h rnd=%0d", pulses, ps, rnd);
        end
    endtask

    task automatic test_async_reset();
        run_draw(16'h0001, 4'd7, 1'b0);
        req   = 1'b1;
        limit = 4'd9;
        tick();
        req = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0 || ps !== 16'h0 || rnd !== 4'd0 ||
            rnd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: busy=%b ps=%h rnd=%0d v=%b",
                     busy, ps, rnd, rnd_valid);
        end
        tick();
        n_vec++;
        if (busy !== 1'b0 || ps !== 16'h0) begin
            n_err++;
            $display("FAIL reset_hold: busy=%b ps=%h", busy, ps);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] s;
        logic [3:0]  l;
        for (int i = 0; i < 2000; i++) begin
            s = 16'($urandom);
            l = 4'($urandom_range(15, 1));
            if (i % 4 == 0) l = 4'd1;
            run_draw(s, l, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic_draw();
        test_zero_limit();
        test_lockup();
        test_abort();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
